// File: rtl/data_path_regs_pkg.sv
// data_path_regs_pkg
//   Shared constants and helpers for the register-read / write-back /
//   immediate stage of the 16-bit multi-cycle processor.
//   - WIDTH, NREGS, AW      : datapath width, register count, address width
//   - OP_R / OP_J / OP_JAL  : opcodes that select the immediate format
//   - *_MSB / *_LSB         : immediate field positions in the instruction
//   - ext_imm()             : immediate extension, including branch scaling
package data_path_regs_pkg;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NREGS = 8;
   localparam int unsigned AW    = $clog2(NREGS);

   localparam logic [2:0] OP_R   = 3'b000;
   localparam logic [2:0] OP_J   = 3'b100;
   localparam logic [2:0] OP_JAL = 3'b101;

   localparam int unsigned OPC_MSB = 2;
   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned J_MSB   = 12;
   localparam int unsigned J_LSB   = 3;
   localparam int unsigned I_MSB   = 12;
   localparam int unsigned I_LSB   = 7;
   localparam int unsigned J_W     = J_MSB - J_LSB + 1;
   localparam int unsigned I_W     = I_MSB - I_LSB + 1;

   typedef enum logic [1:0] {
      IMM_NONE,
      IMM_JUMP,
      IMM_ITYPE
   } imm_kind_t;

   function automatic imm_kind_t imm_kind(input logic [2:0] opcode);
      imm_kind_t k;
      case (opcode)
         OP_R:          k = IMM_NONE;
         OP_J, OP_JAL:  k = IMM_JUMP;
         default:       k = IMM_ITYPE;
      endcase
      return k;
   endfunction

   // Branch offsets are halfword-scaled: shift left one, dropping the MSB.
   function automatic logic [WIDTH-1:0] ext_imm(input logic [WIDTH-1:0] instr,
                                                input logic             branch);
      logic [WIDTH-1:0] ext;
      ext = '0;
      case (imm_kind(instr[OPC_MSB:OPC_LSB]))
         IMM_JUMP:  ext = {{(WIDTH-J_W){instr[J_MSB]}}, instr[J_MSB:J_LSB]};
         IMM_ITYPE: ext = {{(WIDTH-I_W){instr[I_MSB]}}, instr[I_MSB:I_LSB]};
         default:   ext = '0;
      endcase
      if (branch) begin
         ext = {ext[WIDTH-2:0], 1'b0};
      end
      return ext;
   endfunction

endpackage

// File: rtl/data_path_regs_regfile_8x16.sv
// regfile_8x16
//   8 x 16-bit register file, one write port, two registered read ports.
//   - clk, rst_n        : rising-edge clock, async active-low reset (clears all)
//   - we, wa, wd        : write enable, index, data
//   - ra_a, ra_b        : read indices
//   - rd_a, rd_b        : read data, registered (1-cycle latency)
//   Reads sample the pre-edge contents, so a same-edge write is not visible
//   until the following edge.
module regfile_8x16
   import data_path_regs_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [AW-1:0]    ra_a,
   input  logic [AW-1:0]    ra_b,
   output logic [WIDTH-1:0] rd_a,
   output logic [WIDTH-1:0] rd_b
);

   logic [WIDTH-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
         rd_a <= '0;
         rd_b <= '0;
      end else begin
         rd_a <= mem[ra_a];
         rd_b <= mem[ra_b];
         if (we) begin
            mem[wa] <= wd;
         end
      end
   end

endmodule

// File: rtl/data_path_regs.sv
// data_path_regs
//   Register-read / write-back / immediate stage of the 16-bit multi-cycle CPU.
//   - CLK, RST_N                    : rising-edge clock, async active-low reset
//   - input_reg_readA/B_address     : read port indices
//   - input_reg_write(_address)     : write enable and index
//   - input_ALUOut, input_MDR       : write-back sources, memToReg selects MDR
//   - input_imm, input_branch       : instruction word, branch-offset mode
//   - output_reg_A/B                : registered read data
//   - output_imm                    : registered extended immediate
module data_path_regs
   import data_path_regs_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [AW-1:0]    input_reg_readA_address,
   input  logic [AW-1:0]    input_reg_readB_address,
   input  logic             input_reg_write,
   input  logic [AW-1:0]    input_reg_write_address,
   input  logic [WIDTH-1:0] input_imm,
   input  logic             input_branch,
   input  logic [WIDTH-1:0] input_ALUOut,
   input  logic [WIDTH-1:0] input_MDR,
   input  logic             memToReg,
   output logic [WIDTH-1:0] output_imm,
   output logic [WIDTH-1:0] output_reg_A,
   output logic [WIDTH-1:0] output_reg_B
);

   logic [WIDTH-1:0] wb_data;

   always_comb begin
      wb_data = input_ALUOut;
      if (memToReg) begin
         wb_data = input_MDR;
      end
   end

   regfile_8x16 u_regfile (
      .clk   (CLK),
      .rst_n (RST_N),
      .we    (input_reg_write),
      .wa    (input_reg_write_address),
      .wd    (wb_data),
      .ra_a  (input_reg_readA_address),
      .ra_b  (input_reg_readB_address),
      .rd_a  (output_reg_A),
      .rd_b  (output_reg_B)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         output_imm <= '0;
      end else begin
         output_imm <= ext_imm(input_imm, input_branch);
      end
   end

endmodule

// File: tb/tb_data_path_regs.sv
module tb_data_path_regs;

   logic        CLK;
   logic        RST_N;
   logic [2:0]  ra, rb, wa;
   logic        wr;
   logic [15:0] imm_in;
   logic        branch;
   logic [15:0] alu, mdr;
   logic        m2r;
   logic [15:0] out_imm, out_a, out_b;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [15:0] mdl [8];
   logic [15:0] exp_a, exp_b, exp_imm;

   data_path_regs dut (
      .CLK                     (CLK),
      .RST_N                   (RST_N),
      .input_reg_readA_address (ra),
      .input_reg_readB_address (rb),
      .input_reg_write         (wr),
      .input_reg_write_address (wa),
      .input_imm               (imm_in),
      .input_branch            (branch),
      .input_ALUOut            (alu),
      .input_MDR               (mdr),
      .memToReg                (m2r),
      .output_imm              (out_imm),
      .output_reg_A            (out_a),
      .output_reg_B            (out_b)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference immediate: decode fields as signed integers, scale by two for branches.
   function automatic logic [15:0] ref_imm(input logic [15:0] ins, input logic br);
      int op, v;
      logic [31:0] r;
      op = int'(ins) % 8;
      if (op == 0) begin
         v = 0;
      end else if (op == 4 || op == 5) begin
         v = (int'(ins) / 8) % 1024;
         if (v >= 512) v = v - 1024;
      end else begin
         v = (int'(ins) / 128) % 64;
         if (v >= 32) v = v - 64;
      end
      if (br) v = v * 2;
      r = v;
      return r[15:0];
   endfunction

   // One clock edge: predict outputs from pre-edge state, apply write, compare.
   task automatic step();
      @(posedge CLK);
      exp_a   = mdl[ra];
      exp_b   = mdl[rb];
      exp_imm = ref_imm(imm_in, branch);
      if (wr) mdl[wa] = m2r ? mdr : alu;
      #1;
      check("reg_A", out_a, exp_a);
      check("reg_B", out_b, exp_b);
      check("imm", out_imm, exp_imm);
   endtask

   task automatic drive(input logic w, input logic [2:0] a_w, input logic [15:0] a_alu,
                        input logic [15:0] a_mdr, input logic a_m2r);
      @(negedge CLK);
      wr = w; wa = a_w; alu = a_alu; mdr = a_mdr; m2r = a_m2r;
   endtask

   initial begin
      RST_N = 1'b0;
      ra = '0; rb = '0; wa = '0; wr = 1'b0;
      imm_in = '0; branch = 1'b0; alu = '0; mdr = '0; m2r = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      #12;
      check("rst_A", out_a, 16'h0000);
      check("rst_B", out_b, 16'h0000);
      check("rst_imm", out_imm, 16'h0000);
      @(negedge CLK);
      RST_N = 1'b1;

      // Write-back mux
      drive(1'b1, 3'd0, 16'hABBA, 16'h1111, 1'b0); step();
      drive(1'b1, 3'd1, 16'h2222, 16'h0B01, 1'b1); step();
      drive(1'b1, 3'd7, 16'h5AD0, 16'h3333, 1'b0); step();
      drive(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0); ra = 3'd0; rb = 3'd1; step();
      check("wb_alu_r0", out_a, 16'hABBA);
      check("wb_mdr_r1", out_b, 16'h0B01);
      @(negedge CLK); rb = 3'd7; step();
      check("wb_alu_r7", out_b, 16'h5AD0);

      // Immediate formats
      @(negedge CLK); imm_in = 16'b000_111111_0000_010; branch = 1'b0; step();
      check("itype_neg", out_imm, 16'hFFFF);
      @(negedge CLK); imm_in = 16'b000_011111_0000_010; step();
      check("itype_pos", out_imm, 16'h001F);
      @(negedge CLK); imm_in = 16'b000_1100110011_100; step();
      check("jal", out_imm, 16'hFF33);
      @(negedge CLK); branch = 1'b1; step();
      check("jal_branch", out_imm, 16'hFE66);
      @(negedge CLK); imm_in = 16'hFFF8; branch = 1'b0; step();
      check("rtype", out_imm, 16'h0000);
      @(negedge CLK); branch = 1'b1; step();
      check("rtype_branch", out_imm, 16'h0000);

      // Same-edge write/read returns old value; disabled write keeps contents
      drive(1'b1, 3'd2, 16'h2024, 16'h0000, 1'b0); rb = 3'd2; step();
      check("wr_rd_old", out_b, 16'h0000);
      drive(1'b0, 3'd2, 16'h9876, 16'h9876, 1'b0); step();
      check("wr_rd_new", out_b, 16'h2024);
      step();
      check("wr_disabled", out_b, 16'h2024);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         @(negedge CLK);
         ra = 3'($urandom_range(7)); rb = 3'($urandom_range(7));
         wa = 3'($urandom_range(7)); wr = 1'($urandom);
         alu = 16'($urandom); mdr = 16'($urandom); m2r = 1'($urandom);
         imm_in = 16'($urandom); branch = 1'($urandom);
         step();
      end

      // Mid-cycle asynchronous reset
      @(negedge CLK);
      wr = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      check("mid_rst_A", out_a, 16'h0000);
      check("mid_rst_B", out_b, 16'h0000);
      check("mid_rst_imm", out_imm, 16'h0000);
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         ra = 3'(i); rb = 3'(7 - i); imm_in = 16'h0000;
         step();
         check("post_rst_A", out_a, 16'h0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
